// File: rtl/pipe_fetch_buffer.sv
// pipe_fetch_buffer: credit-limited sequential instruction fetch with an
// in-order prefetch FIFO; flushes and restarts on a control-flow redirect.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   redirect, redirectAddress   flush and restart fetch at a new address
//   stepPipe                    decode consumes the head entry
//   instructionValid/instruction/instructionAddress  FIFO head to decode
//   addressMisaligned           last redirect target was misaligned
//   fetchAddress/fetchEnable/fetchReady  memory request handshake
//   fetchDataValid/fetchData    in-order memory responses
module pipe_fetch_buffer #(
    parameter logic [31:0] PROGRAM_COUNTER_RESET = 32'h0,
    parameter int          BUFFER_DEPTH          = 4,
    parameter int          INSTRUCTION_WIDTH     = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         redirect,
    input  logic [31:0]                  redirectAddress,
    input  logic                         stepPipe,
    output logic                         instructionValid,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic [31:0]                  instructionAddress,
    output logic                         addressMisaligned,
    output logic [31:0]                  fetchAddress,
    output logic                         fetchEnable,
    input  logic                         fetchReady,
    input  logic                         fetchDataValid,
    input  logic [INSTRUCTION_WIDTH-1:0] fetchData
);

    localparam int          PW      = $clog2(BUFFER_DEPTH);
    localparam int          CW      = PW + 1;
    localparam logic [31:0] STEP    = 32'(INSTRUCTION_WIDTH / 8);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(BUFFER_DEPTH);
    localparam logic [PW-1:0] P_ONE = PW'(1);
    localparam logic [CW-1:0] C_ONE = CW'(1);

    logic [31:0]                  fetch_pc;
    logic [INSTRUCTION_WIDTH-1:0] data_q [BUFFER_DEPTH];
    logic [31:0]                  addr_q [BUFFER_DEPTH];
    logic [31:0]                  tag_q  [BUFFER_DEPTH];
    logic [PW-1:0]                rd_ptr;
    logic [PW-1:0]                wr_ptr;
    logic [PW-1:0]                tag_rd;
    logic [PW-1:0]                tag_wr;
    logic [CW-1:0]                count;
    logic [CW-1:0]                in_flight;
    logic [CW-1:0]                drop_count;
    logic                         misaligned;

    logic [CW:0] credit_used;
    logic        req;
    logic        head_valid;
    logic        push;
    logic        pop;

    // Buffered plus outstanding words may never exceed the FIFO size, so
    // every response is guaranteed a slot.
    assign credit_used = {1'b0, count} + {1'b0, in_flight};
    assign fetchEnable = rst_n && !misaligned && !redirect
                         && (credit_used < DEPTH_C);
    assign fetchAddress = fetch_pc;
    assign req = fetchEnable && fetchReady;

    assign head_valid = (count != '0);
    assign push = fetchDataValid && !redirect && (drop_count == '0);
    assign pop  = stepPipe && head_valid && !redirect;

    assign instructionValid   = head_valid;
    assign instruction        = head_valid ? data_q[rd_ptr] : '1;
    assign instructionAddress = addr_q[rd_ptr];
    assign addressMisaligned  = misaligned;

    // The tag FIFO records the address of every issued request and is
    // popped by every response, dropped or not, so it survives redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc   <= PROGRAM_COUNTER_RESET;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            tag_rd     <= '0;
            tag_wr     <= '0;
            count      <= '0;
            in_flight  <= '0;
            drop_count <= '0;
            misaligned <= 1'b0;
            for (int i = 0; i < BUFFER_DEPTH; i++) begin
                addr_q[i] <= PROGRAM_COUNTER_RESET;
                tag_q[i]  <= PROGRAM_COUNTER_RESET;
            end
        end else begin
            if (req) begin
                tag_q[tag_wr] <= fetch_pc;
                tag_wr        <= tag_wr + P_ONE;
            end
            if (fetchDataValid) begin
                tag_rd <= tag_rd + P_ONE;
            end
            if (redirect) begin
                fetch_pc   <= redirectAddress;
                misaligned <= |redirectAddress[1:0];
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                count      <= '0;
                in_flight  <= in_flight - CW'(fetchDataValid);
                drop_count <= in_flight - CW'(fetchDataValid);
            end else begin
                if (req) begin
                    fetch_pc <= fetch_pc + STEP;
                end
                if (fetchDataValid && (drop_count != '0)) begin
                    drop_count <= drop_count - C_ONE;
                end
                if (push) begin
                    addr_q[wr_ptr] <= tag_q[tag_rd];
                    wr_ptr         <= wr_ptr + P_ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + P_ONE;
                end
                unique case ({push, pop})
                    2'b10:   count <= count + C_ONE;
                    2'b01:   count <= count - C_ONE;
                    default: count <= count;
                endcase
                unique case ({req, fetchDataValid})
                    2'b10:   in_flight <= in_flight + C_ONE;
                    2'b01:   in_flight <= in_flight - C_ONE;
                    default: in_flight <= in_flight;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr] <= fetchData;
        end
    end

endmodule

// File: tb/tb_pipe_fetch_buffer.sv
// Testbench for pipe_fetch_buffer: directed vectors and corner sequences
// against two configurations, with behavioural in-order memories.
module tb_pipe_fetch_buffer;

    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_address;
    logic        step_pipe;
    logic        ivalid;
    logic [31:0] instr;
    logic [31:0] iaddr;
    logic        mis;
    logic [31:0] faddr;
    logic        fen;
    logic        frdy;
    logic        fdv;
    logic [31:0] fdata;

    logic        step2;
    logic        redirect2;
    logic [31:0] redirect_address2;
    logic        ivalid2;
    logic [31:0] instr2;
    logic [31:0] iaddr2;
    logic        mis2;
    logic [31:0] faddr2;
    logic        fen2;
    logic        frdy2;
    logic        fdv2;
    logic [31:0] fdata2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat = 1;

    typedef struct {
        logic [31:0] a;
        int          due;
    } req_t;

    req_t mq[$];
    req_t mq2[$];

    typedef struct {
        logic        step;
        logic        v;
        logic [31:0] ia;
        logic        en;
        logic [31:0] fa;
    } vec_t;

    vec_t vt[12];

    pipe_fetch_buffer dut (
        .clk(clk),
        .rst_n(rst_n),
        .redirect(redirect),
        .redirectAddress(redirect_address),
        .stepPipe(step_pipe),
        .instructionValid(ivalid),
        .instruction(instr),
        .instructionAddress(iaddr),
        .addressMisaligned(mis),
        .fetchAddress(faddr),
        .fetchEnable(fen),
        .fetchReady(frdy),
        .fetchDataValid(fdv),
        .fetchData(fdata)
    );

    pipe_fetch_buffer #(
        .PROGRAM_COUNTER_RESET(32'hFFFF_FFF8),
        .BUFFER_DEPTH(2),
        .INSTRUCTION_WIDTH(32)
    ) dut2 (
        .clk(clk),
        .rst_n(rst_n),
        .redirect(redirect2),
        .redirectAddress(redirect_address2),
        .stepPipe(step2),
        .instructionValid(ivalid2),
        .instruction(instr2),
        .instructionAddress(iaddr2),
        .addressMisaligned(mis2),
        .fetchAddress(faddr2),
        .fetchEnable(fen2),
        .fetchReady(frdy2),
        .fetchDataValid(fdv2),
        .fetchData(fdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] fd(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // Memory models: accept at the edge ending the request cycle, answer
    // in order 'lat' cycles after the request cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            mq2.delete();
        end else begin
            if (fen && frdy) mq.push_back('{faddr, cyc + lat});
            if (fen2 && frdy2) mq2.push_back('{faddr2, cyc + 1});
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        #1;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            fdv = 1'b1;
            fdata = fd(mq[0].a);
            void'(mq.pop_front());
        end else begin
            fdv = 1'b0;
            fdata = '0;
        end
        if (mq2.size() > 0 && mq2[0].due <= cyc) begin
            fdv2 = 1'b1;
            fdata2 = fd(mq2[0].a);
            void'(mq2.pop_front());
        end else begin
            fdv2 = 1'b0;
            fdata2 = '0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    // Asserts reset (asynchronously, wherever we are in the cycle), checks
    // the reset outputs, then releases it just after an edge.
    task automatic do_reset;
        rst_n = 1'b0;
        #1;
        chk("rst_en", fen, 0);
        chk("rst_valid", ivalid, 0);
        chk("rst_instr", instr, 32'hFFFF_FFFF);
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_mis", mis, 0);
        chk("rst_faddr", faddr, 32'h0);
        chk("rst2_faddr", faddr2, 32'hFFFF_FFF8);
        chk("rst2_iaddr", iaddr2, 32'hFFFF_FFF8);
        chk("rst2_en", fen2, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        redirect = 1'b0;
        redirect_address = '0;
        step_pipe = 1'b0;
        frdy = 1'b1;
        fdv = 1'b0;
        fdata = '0;
        step2 = 1'b0;
        redirect2 = 1'b0;
        redirect_address2 = '0;
        frdy2 = 1'b1;
        fdv2 = 1'b0;
        fdata2 = '0;

        vt[0]  = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd0};
        vt[1]  = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd4};
        vt[2]  = '{1'b0, 1'b1, 32'd0,  1'b1, 32'd8};
        vt[3]  = '{1'b0, 1'b1, 32'd0,  1'b1, 32'd12};
        vt[4]  = '{1'b0, 1'b1, 32'd0,  1'b0, 32'd16};
        vt[5]  = '{1'b1, 1'b1, 32'd0,  1'b0, 32'd16};
        vt[6]  = '{1'b1, 1'b1, 32'd4,  1'b1, 32'd16};
        vt[7]  = '{1'b1, 1'b1, 32'd8,  1'b1, 32'd20};
        vt[8]  = '{1'b1, 1'b1, 32'd12, 1'b1, 32'd24};
        vt[9]  = '{1'b1, 1'b1, 32'd16, 1'b1, 32'd28};
        vt[10] = '{1'b1, 1'b1, 32'd20, 1'b1, 32'd32};
        vt[11] = '{1'b1, 1'b1, 32'd24, 1'b1, 32'd36};

        #3;
        lat = 1;
        do_reset();

        // Fill to the credit limit, then stream one per cycle.
        for (int i = 0; i < 12; i++) begin
            step_pipe = vt[i].step;
            @(negedge clk);
            chk($sformatf("t1_valid[%0d]", i), ivalid, vt[i].v);
            chk($sformatf("t1_en[%0d]", i), fen, vt[i].en);
            chk($sformatf("t1_faddr[%0d]", i), faddr, vt[i].fa);
            if (vt[i].v) begin
                chk($sformatf("t1_iaddr[%0d]", i), iaddr, vt[i].ia);
                chk($sformatf("t1_instr[%0d]", i), instr, fd(vt[i].ia));
            end else begin
                chk($sformatf("t1_instr_idle[%0d]", i), instr,
                    32'hFFFF_FFFF);
            end
            next_cyc();
        end

        // Three requests in flight, redirect to 0x100.
        step_pipe = 1'b0;
        lat = 4;
        do_reset();
        repeat (3) next_cyc();
        redirect = 1'b1;
        redirect_address = 32'h100;
        @(negedge clk);
        chk("t3_en_redir", fen, 0);
        next_cyc();
        redirect = 1'b0;
        @(negedge clk);
        chk("t3_faddr", faddr, 32'h100);
        chk("t3_en", fen, 1);
        chk("t3_valid_c4", ivalid, 0);
        next_cyc();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("t3_no_stale[%0d]", k), ivalid, 0);
            next_cyc();
        end
        @(negedge clk);
        chk("t3_valid", ivalid, 1);
        chk("t3_iaddr", iaddr, 32'h100);
        chk("t3_instr", instr, fd(32'h100));

        // Redirect with a response and a pop in the same cycle.
        next_cyc();
        lat = 2;
        do_reset();
        repeat (3) next_cyc();
        @(negedge clk);
        chk("t4_head_pre", iaddr, 32'h0);
        chk("t4_valid_pre", ivalid, 1);
        next_cyc();
        redirect = 1'b1;
        redirect_address = 32'h40;
        step_pipe = 1'b1;
        @(negedge clk);
        chk("t4_en_redir", fen, 0);
        next_cyc();
        redirect = 1'b0;
        step_pipe = 1'b0;
        @(negedge clk);
        chk("t4_valid_c4", ivalid, 0);
        chk("t4_faddr", faddr, 32'h40);
        chk("t4_en", fen, 1);
        next_cyc();
        @(negedge clk);
        chk("t4_valid_c5", ivalid, 0);
        next_cyc();
        @(negedge clk);
        chk("t4_valid_c6", ivalid, 0);
        next_cyc();
        @(negedge clk);
        chk("t4_valid_c7", ivalid, 1);
        chk("t4_iaddr", iaddr, 32'h40);
        chk("t4_instr", instr, fd(32'h40));

        // Misaligned redirect, recovery, then async reset clears the flag.
        next_cyc();
        lat = 1;
        step_pipe = 1'b1;
        do_reset();
        repeat (4) next_cyc();
        redirect = 1'b1;
        redirect_address = 32'h102;
        next_cyc();
        redirect = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("t5_mis[%0d]", k), mis, 1);
            chk($sformatf("t5_en_off[%0d]", k), fen, 0);
            chk($sformatf("t5_valid_off[%0d]", k), ivalid, 0);
            next_cyc();
        end
        redirect = 1'b1;
        redirect_address = 32'h200;
        next_cyc();
        redirect = 1'b0;
        @(negedge clk);
        chk("t5_mis_clr", mis, 0);
        chk("t5_faddr", faddr, 32'h200);
        chk("t5_en", fen, 1);
        next_cyc();
        next_cyc();
        @(negedge clk);
        chk("t5_valid", ivalid, 1);
        chk("t5_iaddr", iaddr, 32'h200);
        chk("t5_instr", instr, fd(32'h200));
        next_cyc();
        redirect = 1'b1;
        redirect_address = 32'h302;
        next_cyc();
        redirect = 1'b0;
        step_pipe = 1'b0;
        @(negedge clk);
        chk("t5_mis_again", mis, 1);
        do_reset();

        // Wrapping PC with a two-entry buffer.
        @(negedge clk);
        chk("t6_en_c0", fen2, 1);
        chk("t6_fa_c0", faddr2, 32'hFFFF_FFF8);
        next_cyc();
        @(negedge clk);
        chk("t6_en_c1", fen2, 1);
        chk("t6_fa_c1", faddr2, 32'hFFFF_FFFC);
        next_cyc();
        @(negedge clk);
        chk("t6_en_c2", fen2, 0);
        chk("t6_fa_c2", faddr2, 32'h0);
        chk("t6_valid_c2", ivalid2, 1);
        chk("t6_ia_c2", iaddr2, 32'hFFFF_FFF8);
        next_cyc();
        step2 = 1'b1;
        @(negedge clk);
        chk("t6_en_c3", fen2, 0);
        next_cyc();
        step2 = 1'b0;
        @(negedge clk);
        chk("t6_en_c4", fen2, 1);
        chk("t6_fa_c4", faddr2, 32'h0);
        chk("t6_ia_c4", iaddr2, 32'hFFFF_FFFC);
        next_cyc();
        @(negedge clk);
        chk("t6_en_c5", fen2, 0);
        next_cyc();
        step2 = 1'b1;
        @(negedge clk);
        chk("t6_en_c6", fen2, 0);
        next_cyc();
        step2 = 1'b0;
        @(negedge clk);
        chk("t6_valid_c7", ivalid2, 1);
        chk("t6_ia_c7", iaddr2, 32'h0);
        chk("t6_instr_c7", instr2, fd(32'h0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
